// File: rtl/tile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// tile_writeback_pkg
//   Shared types for the tile writeback slice.
//   - color_rgb_t     : 24-bit pixel colour as produced by the SPUs (r in MSBs)
//   - wb_state_t      : writeback sequencer states
//   - BYTES_PER_PIXEL : back-buffer pixel stride in bytes (packed RGB)
// -----------------------------------------------------------------------------
package tile_writeback_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_LATCH   = 3'd2,
    ST_WRITE_R = 3'd3,
    ST_WRITE_G = 3'd4,
    ST_WRITE_B = 3'd5,
    ST_DONE    = 3'd6
  } wb_state_t;

endpackage : tile_writeback_pkg

// File: rtl/pixel_address.sv
// -----------------------------------------------------------------------------
// pixel_address
//   Combinational back-buffer byte address of the red byte of a screen pixel:
//     address = base + BYTES_PER_PIXEL * (screen_y * SCREEN_WIDTH + screen_x)
//   All arithmetic is 32 bits and wraps modulo 2^32.
// Ports:
//   base     in  32  back-buffer byte base address
//   screen_x in  32  screen column
//   screen_y in  32  screen row
//   address  out 32  byte address of the pixel's red component
// -----------------------------------------------------------------------------
module pixel_address
  import tile_writeback_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 640
) (
  input  logic [31:0] base,
  input  logic [31:0] screen_x,
  input  logic [31:0] screen_y,
  output logic [31:0] address
);

  logic [31:0] linear;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally); a path that leaves one unassigned infers a latch.
  always_comb begin
    linear  = screen_y * 32'(SCREEN_WIDTH) + screen_x;
    address = base + linear * 32'(BYTES_PER_PIXEL);
  end

endmodule : pixel_address

// File: rtl/tile_writeback.sv
// -----------------------------------------------------------------------------
// tile_writeback
//   Walks the 2x2 group of SPU tiles (0x0, 1x0, 0x1, 1x1), asks the SPUs for
//   each pixel colour and writes it to the back buffer as three byte writes
//   (r, g, b). Pixels falling outside the screen are fetched but not written.
// Ports:
//   i_clock            in   1  rising-edge clock
//   i_reset_n          in   1  asynchronous active-low reset
//   i_enable           in   1  global stall; low freezes all state and outputs
//   i_start            in   1  start request, honoured only in Idle
//   i_back_base        in  32  back-buffer byte base, sampled on start
//   i_tile_x/i_tile_y  in  10  screen origin of tile 0x0, sampled on start
//   o_get_color        out  1  colour request strobe to the SPUs
//   o_x/o_y            out  clog2(TILE_SIZE)  in-tile pixel coordinate
//   i_tile*_color      in  24  SPU colour results, valid one cycle after request
//   o_mem_write        out  1  byte write request
//   o_mem_address      out 32  byte address
//   o_mem_data         out  8  byte data
//   i_mem_valid        in   1  write accepted (sampled in write states only)
//   o_busy             out  1  writeback in progress
//   o_done             out  1  single-cycle completion pulse
// TILE_SIZE must be at least 2.
// -----------------------------------------------------------------------------
module tile_writeback
  import tile_writeback_pkg::*;
#(
  parameter int unsigned TILE_SIZE     = 10,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_enable,
  input  logic                         i_start,
  input  logic [31:0]                  i_back_base,
  input  logic [9:0]                   i_tile_x,
  input  logic [9:0]                   i_tile_y,
  output logic                         o_get_color,
  output logic [$clog2(TILE_SIZE)-1:0] o_x,
  output logic [$clog2(TILE_SIZE)-1:0] o_y,
  input  color_rgb_t                   i_tile0x0_color,
  input  color_rgb_t                   i_tile1x0_color,
  input  color_rgb_t                   i_tile0x1_color,
  input  color_rgb_t                   i_tile1x1_color,
  output logic                         o_mem_write,
  output logic [31:0]                  o_mem_address,
  output logic [7:0]                   o_mem_data,
  input  logic                         i_mem_valid,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned CW = $clog2(TILE_SIZE);
  localparam logic [CW-1:0] LAST_COORD = CW'(TILE_SIZE - 1);

  wb_state_t   state;
  logic [31:0] base_q;
  logic [9:0]  tile_x_q;
  logic [9:0]  tile_y_q;
  logic [1:0]  tile_idx;   // bit 0: x tile, bit 1: y tile
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  color_rgb_t  color_q;

  // Current pixel in screen space and the bookkeeping for the next pixel.
  logic [31:0]   off_x, off_y;
  logic [31:0]   screen_x, screen_y;
  logic [31:0]   pix_addr;
  logic          in_screen;
  color_rgb_t    sel_color;
  logic          last_x, last_y, last_pixel;
  logic [CW-1:0] next_x, next_y;
  logic [1:0]    next_tile;
  logic          advance;

  assign o_x = x_q;
  assign o_y = y_q;

  always_comb begin
    off_x     = tile_idx[0] ? 32'(TILE_SIZE) : 32'd0;
    off_y     = tile_idx[1] ? 32'(TILE_SIZE) : 32'd0;
    screen_x  = 32'(tile_x_q) + off_x + 32'(x_q);
    screen_y  = 32'(tile_y_q) + off_y + 32'(y_q);
    in_screen = (screen_x < 32'(SCREEN_WIDTH)) && (screen_y < 32'(SCREEN_HEIGHT));

    case (tile_idx)
      2'd0:    sel_color = i_tile0x0_color;
      2'd1:    sel_color = i_tile1x0_color;
      2'd2:    sel_color = i_tile0x1_color;
      default: sel_color = i_tile1x1_color;
    endcase

    last_x     = (x_q == LAST_COORD);
    last_y     = (y_q == LAST_COORD);
    last_pixel = last_x && last_y && (tile_idx == 2'd3);
    next_x     = last_x ? '0 : x_q + CW'(1);
    next_y     = last_x ? (last_y ? '0 : y_q + CW'(1)) : y_q;
    next_tile  = (last_x && last_y) ? tile_idx + 2'd1 : tile_idx;

    // A pixel is finished after its blue byte is accepted, or straight after
    // Latch when it lies off screen.
    advance = ((state == ST_LATCH) && !in_screen) ||
              ((state == ST_WRITE_B) && i_mem_valid);
  end

  pixel_address #(
    .SCREEN_WIDTH(SCREEN_WIDTH)
  ) u_pixel_address (
    .base     (base_q),
    .screen_x (screen_x),
    .screen_y (screen_y),
    .address  (pix_addr)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the datapath registers (latched colour, counters, sampled
      // inputs) are reset too, so a restart never sees stale values.
      state         <= ST_IDLE;
      base_q        <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      tile_idx      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      o_get_color   <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else if (i_enable) begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base_q      <= i_back_base;
            tile_x_q    <= i_tile_x;
            tile_y_q    <= i_tile_y;
            tile_idx    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            o_busy      <= 1'b1;
            o_get_color <= 1'b1;
            state       <= ST_REQUEST;
          end
        end

        ST_REQUEST: begin
          o_get_color <= 1'b0;
          state       <= ST_LATCH;
        end

        ST_LATCH: begin
          if (in_screen) begin
            color_q       <= sel_color;
            o_mem_write   <= 1'b1;
            o_mem_address <= pix_addr;
            o_mem_data    <= sel_color.r;
            state         <= ST_WRITE_R;
          end
        end

        // Address and data only move on the cycle after the bus accepts.
        ST_WRITE_R: begin
          if (i_mem_valid) begin
            o_mem_address <= o_mem_address + 32'd1;
            o_mem_data    <= color_q.g;
            state         <= ST_WRITE_G;
          end else begin
            o_mem_data    <= color_q.r;
          end
        end

        ST_WRITE_G: begin
          if (i_mem_valid) begin
            o_mem_address <= o_mem_address + 32'd1;
            o_mem_data    <= color_q.b;
            state         <= ST_WRITE_B;
          end else begin
            o_mem_data    <= color_q.g;
          end
        end

        ST_WRITE_B: begin
          if (i_mem_valid) begin
            o_mem_write <= 1'b0;
          end else begin
            o_mem_data  <= color_q.b;
          end
        end

        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      if (advance) begin
        x_q      <= next_x;
        y_q      <= next_y;
        tile_idx <= next_tile;
        if (last_pixel) begin
          o_done <= 1'b1;
          state  <= ST_DONE;
        end else begin
          o_get_color <= 1'b1;
          state       <= ST_REQUEST;
        end
      end
    end
  end

endmodule : tile_writeback

// File: tb/tb_tile_writeback.sv
// -----------------------------------------------------------------------------
// tb_tile_writeback
//   Directed bench for tile_writeback. Each job pushes its expected byte writes
//   into a queue; a negedge monitor pops and compares every accepted write.
// -----------------------------------------------------------------------------
module tb_tile_writeback;
  import tile_writeback_pkg::*;

  localparam int unsigned TS = 10;
  localparam int unsigned SW = 640;
  localparam int unsigned SH = 480;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        i_clock     = 1'b0;
  logic        i_reset_n   = 1'b0;
  logic        i_enable    = 1'b1;
  logic        i_start     = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic [31:0] i_back_base = '0;
  logic [9:0]  i_tile_x    = '0;
  logic [9:0]  i_tile_y    = '0;
  color_rgb_t  col [4];

  logic        o_get_color;
  logic [3:0]  o_x, o_y;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [7:0]  o_mem_data;
  logic        o_busy, o_done;

  tile_writeback #(
    .TILE_SIZE(TS), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_enable        (i_enable),
    .i_start         (i_start),
    .i_back_base     (i_back_base),
    .i_tile_x        (i_tile_x),
    .i_tile_y        (i_tile_y),
    .o_get_color     (o_get_color),
    .o_x             (o_x),
    .o_y             (o_y),
    .i_tile0x0_color (col[0]),
    .i_tile1x0_color (col[1]),
    .i_tile0x1_color (col[2]),
    .i_tile1x1_color (col[3]),
    .o_mem_write     (o_mem_write),
    .o_mem_address   (o_mem_address),
    .o_mem_data      (o_mem_data),
    .i_mem_valid     (i_mem_valid),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 i_clock = ~i_clock;

  int unsigned cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_fail = 0;
  wr_t         exp_q[$];
  wr_t         log_q[$];
  int          done_count = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  int          valid_delay = 0;
  int          wait_cnt = 0;
  bit          pend_valid = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [7:0]  pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: valid tied high, or raised after valid_delay wait cycles
  // per presented byte.
  always @(posedge i_clock) begin
    #1;
    if (valid_delay == 0) begin
      i_mem_valid = 1'b1;
    end else if (o_mem_write && i_enable) begin
      if (wait_cnt >= valid_delay) begin
        i_mem_valid = 1'b1;
        wait_cnt    = 0;
      end else begin
        i_mem_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      i_mem_valid = 1'b0;
    end
  end

  // Monitor: compares every byte the bus accepts against the expected queue,
  // and checks that a waiting byte holds its address and data.
  always @(negedge i_clock) begin
    wr_t w;
    wr_t e;
    if (i_reset_n && i_enable) begin
      if (o_mem_write) begin
        if (pend_valid) begin
          check("hold_addr", o_mem_address, pend_addr);
          check("hold_data", 32'(o_mem_data), 32'(pend_data));
        end
        if (i_mem_valid) begin
          pend_valid = 1'b0;
          w.addr = o_mem_address;
          w.data = o_mem_data;
          log_q.push_back(w);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h, expected no write",
                     o_mem_address, o_mem_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", o_mem_address, e.addr);
            check("wr_data", 32'(o_mem_data), 32'(e.data));
          end
        end else begin
          pend_valid = 1'b1;
          pend_addr  = o_mem_address;
          pend_data  = o_mem_data;
        end
      end
      if (o_done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic set_colors(input logic [23:0] c0, input logic [23:0] c1,
                            input logic [23:0] c2, input logic [23:0] c3);
    col[0] = c0;
    col[1] = c1;
    col[2] = c2;
    col[3] = c3;
  endtask

  // Pushes the expected writes for one job, then pulses i_start for one cycle.
  task automatic launch(input logic [31:0] base, input logic [9:0] tx, input logic [9:0] ty);
    int unsigned sx, sy;
    logic [31:0] a;
    wr_t w;
    for (int t = 0; t < 4; t++) begin
      for (int y = 0; y < int'(TS); y++) begin
        for (int x = 0; x < int'(TS); x++) begin
          sx = 32'(tx) + ((t % 2 == 1) ? TS : 0) + 32'(x);
          sy = 32'(ty) + ((t / 2 == 1) ? TS : 0) + 32'(y);
          if (sx < SW && sy < SH) begin
            a = base + 3 * (sy * SW + sx);
            w.addr = a;      w.data = col[t].r; exp_q.push_back(w);
            w.addr = a + 1;  w.data = col[t].g; exp_q.push_back(w);
            w.addr = a + 2;  w.data = col[t].b; exp_q.push_back(w);
          end
        end
      end
    end
    log_q.delete();
    done_count = 0;
    @(posedge i_clock); #1;
    i_back_base = base;
    i_tile_x    = tx;
    i_tile_y    = ty;
    i_start     = 1'b1;
    start_cyc   = cyc + 1;
    @(posedge i_clock); #1;
    i_start     = 1'b0;
    // Scramble the job inputs: the DUT must have sampled them already.
    i_back_base = 32'hDEAD_BEEF;
    i_tile_x    = 10'h3FF;
    i_tile_y    = 10'h3FF;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    if (done_count == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no o_done within %0d cycles, expected o_done", name, budget);
    end
    repeat (3) @(negedge i_clock);
    check({name, "_busy_clear"}, 32'(o_busy), 32'd0);
    check({name, "_done_pulses"}, 32'(done_count), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] snap, snap_addr, max_addr;
    int n;
    set_colors(24'h0, 24'h0, 24'h0, 24'h0);

    // Reset state
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_mem_write", 32'(o_mem_write), 32'd0);
    check("rst_get_color", 32'(o_get_color), 32'd0);
    check("rst_busy",      32'(o_busy), 32'd0);
    check("rst_done",      32'(o_done), 32'd0);
    check("rst_address",   o_mem_address, 32'd0);
    check("rst_xy_data",   {16'd0, o_x, o_y, o_mem_data}, 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);

    // Job 1: base 0x1000, tile (0,0), uniform colour, zero wait states.
    set_colors(24'h112233, 24'h112233, 24'h112233, 24'h112233);
    valid_delay = 0;
    launch(32'h1000, 10'd0, 10'd0);
    wait_done("j1", 20000);
    check("j1_count",   32'(log_q.size()), 32'd1200);
    check("j1_b0_addr", log_q[0].addr, 32'h1000);
    check("j1_b0_data", 32'(log_q[0].data), 32'h11);
    check("j1_b1_addr", log_q[1].addr, 32'h1001);
    check("j1_b1_data", 32'(log_q[1].data), 32'h22);
    check("j1_b2_addr", log_q[2].addr, 32'h1002);
    check("j1_b2_data", 32'(log_q[2].data), 32'h33);
    check("j1_latency", done_cyc - start_cyc, 32'd2000);

    // Job 2: tile (20,30), base 0, distinct colour per tile.
    set_colors(24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C, 24'h3A3B3C);
    launch(32'h0, 10'd20, 10'd30);
    wait_done("j2", 20000);
    check("j2_count",      32'(log_q.size()), 32'd1200);
    check("j2_first_addr", log_q[0].addr, 32'd57660);
    check("j2_last_addr",  log_q[$].addr, 32'd94199);
    check("j2_last_data",  32'(log_q[$].data), 32'h3C);

    // Job 3: four wait states per byte; 17 cycles per pixel.
    valid_delay = 4;
    launch(32'h10, 10'd100, 10'd200);
    wait_done("j3", 20000);
    check("j3_count",   32'(log_q.size()), 32'd1200);
    check("j3_latency", done_cyc - start_cyc, 32'd6800);

    // Job 4: 10-cycle stall mid-run with i_start held during the stall and
    // pulsed again once running.
    valid_delay = 0;
    set_colors(24'hC0FFEE, 24'hBADA55, 24'h5EED00, 24'h0FF1CE);
    launch(32'h2000, 10'd0, 10'd0);
    n = 0;
    while (log_q.size() < 100 && n < 2000) begin
      @(negedge i_clock);
      n++;
    end
    check("j4_reached_mid", 32'(log_q.size() >= 100), 32'd1);
    @(posedge i_clock); #1;
    i_enable = 1'b0;
    i_start  = 1'b1;
    @(negedge i_clock);
    snap      = {12'd0, o_mem_write, o_get_color, o_busy, o_done, o_x, o_y, o_mem_data};
    snap_addr = o_mem_address;
    for (int i = 1; i < 10; i++) begin
      @(negedge i_clock);
      check("j4_frozen_ctl",  {12'd0, o_mem_write, o_get_color, o_busy, o_done, o_x, o_y, o_mem_data}, snap);
      check("j4_frozen_addr", o_mem_address, snap_addr);
    end
    @(posedge i_clock); #1;
    i_enable = 1'b1;
    @(posedge i_clock); #1;
    i_start  = 1'b0;
    wait_done("j4", 20000);
    check("j4_count",   32'(log_q.size()), 32'd1200);
    check("j4_latency", done_cyc - start_cyc, 32'd2010);

    // Job 5: reset asserted while the green byte of the first pixel waits.
    valid_delay = 4;
    launch(32'h0, 10'd0, 10'd0);
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!(o_mem_write && o_mem_address == 32'h1) && n < 200);
    check("j5_reached_write_g", o_mem_address, 32'h1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("j5_rst_mem_write", 32'(o_mem_write), 32'd0);
    check("j5_rst_address",   o_mem_address, 32'd0);
    check("j5_rst_ctl",       {16'd0, o_get_color, o_busy, o_done, 1'b0, o_x, o_y, 4'd0}, 32'd0);
    check("j5_rst_data",      32'(o_mem_data), 32'd0);
    exp_q.delete();
    pend_valid = 1'b0;
    wait_cnt   = 0;
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    n = log_q.size();
    repeat (30) @(negedge i_clock);
    check("j5_no_writes", 32'(log_q.size()), 32'(n));
    check("j5_idle",      32'(o_busy), 32'd0);
    check("j5_no_done",   32'(done_count), 32'd0);

    // Job 6: group straddling the bottom-right corner; only tile 0x0 is on
    // screen, and the off-screen pixels cost two cycles each.
    valid_delay = 0;
    set_colors(24'h123456, 24'h654321, 24'hABCDEF, 24'hFEDCBA);
    launch(32'h0, 10'd630, 10'd470);
    wait_done("j6", 20000);
    check("j6_count",   32'(log_q.size()), 32'd300);
    check("j6_latency", done_cyc - start_cyc, 32'd1100);
    max_addr = '0;
    foreach (log_q[i]) if (log_q[i].addr > max_addr) max_addr = log_q[i].addr;
    check("j6_max_addr_in_buffer", 32'(max_addr < 32'd921600), 32'd1);
    check("j6_last_addr", max_addr, 32'd921599);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tile_writeback

// File: doc/tile_writeback.md
TILE_WRITEBACK -- requirements
Module: tile_writeback

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 10, edge length in pixels of one SPU tile.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 640, back-buffer width in pixels.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 480, back-buffer height in pixels.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_clock  input  1  rising-edge clock; i_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have i_enable  input  1  global stall; when low, all state and outputs hold.
REQ-006 SHALL have i_start  input  1  single-cycle request to write back the current 2x2 tile group.
REQ-007 SHALL have i_back_base  input  32  back-buffer byte base address, sampled on accepted i_start.
REQ-008 SHALL have i_tile_x, i_tile_y  input  10 each  screen origin of tile 0x0, sampled on accepted i_start.
REQ-009 SHALL have o_get_color  output  1  pixel-colour request strobe to the four SPUs.
REQ-010 SHALL have o_x, o_y  output  clog2(TILE_SIZE) each  in-tile pixel coordinate for o_get_color.
REQ-011 SHALL have i_tile0x0_color, i_tile1x0_color, i_tile0x1_color, i_tile1x1_color  input  ColorRGB (24) each  SPU colour results.
REQ-012 SHALL have o_mem_write  output  1, o_mem_address  output  32, o_mem_data  output  8, i_mem_valid  input  1  byte-write bus.
REQ-013 SHALL have o_busy  output  1 and o_done  output  1 (single-cycle completion pulse).

Function
REQ-014 SHALL use states Idle, Request, Latch, WriteR, WriteG, WriteB, Done.
REQ-015 Idle: i_start high SHALL latch inputs, zero tile index/x/y, assert o_busy, go to Request next cycle; i_start outside Idle SHALL be ignored.
REQ-016 Tiles SHALL be processed in order 0x0, 1x0, 0x1, 1x1 (offsets (0,0), (TILE_SIZE,0), (0,TILE_SIZE), (TILE_SIZE,TILE_SIZE)); within a tile, x fastest, then y.
REQ-017 Request SHALL drive o_get_color=1 with o_x/o_y for exactly one cycle, then go to Latch.
REQ-018 Latch SHALL capture the selected tile's colour input (valid one cycle after o_get_color) into an internal register, then go to WriteR.
REQ-019 Pixel address SHALL be i_back_base + 3*((tile_y+offy+y)*SCREEN_WIDTH + tile_x+offx+x), computed in 32 bits, wrapping modulo 2^32.
REQ-020 WriteR/G/B SHALL drive o_mem_write=1, address +0/+1/+2, data r/g/b, holding all three until i_mem_valid is sampled high, then advance next cycle.
REQ-021 o_mem_write SHALL stay high across consecutive bytes; address/data SHALL change only on the cycle after i_mem_valid.
REQ-022 Screen pixels with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT SHALL be skipped: Latch goes straight to the next pixel's Request, no write.
REQ-023 After WriteB of the last pixel (x=y=TILE_SIZE-1, tile 1x1), state SHALL go to Done; Done SHALL pulse o_done one cycle, clear o_busy, return to Idle.
REQ-024 Unstalled, zero-wait-state latency per written pixel SHALL be 5 cycles; i_mem_valid outside Write states SHALL be ignored.

Reset
REQ-025 i_reset_n low SHALL immediately force state Idle and o_mem_write, o_get_color, o_busy, o_done, o_mem_address, o_mem_data, o_x, o_y to 0, aborting any in-progress writeback with no further bus activity.
REQ-026 Internal counters and latched colour SHALL reset to 0.

Structure
REQ-027 The state enum and constant BYTES_PER_PIXEL=3 SHALL live in the shared types header alongside ColorRGB.
REQ-028 Address arithmetic SHALL be a combinational sub-module pixel_address (inputs base, screen x/y; output 32-bit address).

Verification
REQ-029 Base 0x1000, tile (0,0), valid tied high, colours 0x112233 -> first bytes 0x11@0x1000, 0x22@0x1001, 0x33@0x1002; 1200 writes; o_done at cycle 2000 after start +1.
REQ-030 Tile (20,30), base 0 -> first write address 3*(30*640+20)=57660; last 3*(49*640+39)+2=94199.
REQ-031 Tile (630,470) -> only in-screen pixels written (x<640, y<480), 100 pixels, no address >= 921600.
REQ-032 i_mem_valid delayed 4 cycles per byte -> address/data stable while waiting, no byte skipped or duplicated.
REQ-033 i_reset_n low mid-WriteG, then high -> outputs zero at once, Idle, no writes until new i_start.
REQ-034 i_enable low for 10 cycles mid-run and i_start pulsed while busy -> outputs frozen, second start ignored, final write count unchanged.
